snn_spike_classifier: RTL and testbench

//  Output stage placed directly after the FC output layer of the SNN top. It takes the
//  (w_en, s_index) output-spike stream through a small input FIFO and exposes full/almost_full

---
 rtl/snn_spike_classifier_pkg.sv | 22 ++
 rtl/snn_spike_classifier_spike_in_fifo.sv | 59 +++++
 rtl/snn_spike_classifier.sv | 124 ++++++++++++
 tb/tb_snn_spike_classifier.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/snn_spike_classifier_pkg.sv
// Shared constants, FSM encoding and error-bit positions for the SNN output classifier.
package snn_spike_classifier_pkg;
   localparam int NUM_CLASS  = 10;
   localparam int CLS_W      = 4;
   localparam int CNT_W      = 8;
   localparam int IDX_W      = 16;
   localparam int FIFO_DEPTH = 16;
   localparam int FIFO_AW    = 4;
   localparam int AF_MARGIN  = 2;
   // FIFO entry: {index out of range, low class-index bits}
   localparam int ENT_W      = CLS_W + 1;

   typedef enum logic [1:0] {
      ST_ACCUM = 2'd0,
      ST_SCAN  = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam int ERR_WR_FULL = 0;
   localparam int ERR_BAD_IDX = 1;
   localparam int ERR_FE_PEND = 2;
endpackage

// File: rtl/snn_spike_classifier_spike_in_fifo.sv
// Register-array synchronous FIFO with occupancy tracking and registered full/almost_full.
module spike_in_fifo #(
   parameter int DW        = 5,
   parameter int DEPTH     = 16,
   parameter int AW        = 4,
   parameter int AF_MARGIN = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_push,
   input  logic [DW-1:0] i_din,
   input  logic          i_pop,
   output logic [DW-1:0] o_dout,
   output logic          o_empty,
   output logic          o_full,
   output logic          o_almost_full
);
   logic [DW-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_occ;
   logic [AW:0]   w_occ_nxt;
   logic          w_do_push;
   logic          w_do_pop;

   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && (r_occ != '0);
   assign o_empty   = (r_occ == '0);
   assign o_dout    = r_mem[r_rd_ptr];

   always_comb begin
      w_occ_nxt = r_occ;
      if (w_do_push && !w_do_pop)
         w_occ_nxt = r_occ + (AW+1)'(1);
      else if (w_do_pop && !w_do_push)
         w_occ_nxt = r_occ - (AW+1)'(1);
   end

   // Flags are registered from next occupancy so they line up with r_occ.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_occ         <= '0;
         o_full        <= 1'b0;
         o_almost_full <= 1'b0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         r_occ         <= w_occ_nxt;
         o_full        <= (w_occ_nxt == (AW+1)'(DEPTH));
         o_almost_full <= (w_occ_nxt >= (AW+1)'(DEPTH - AF_MARGIN));
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_din;
   end
endmodule

// File: rtl/snn_spike_classifier.sv
// Counts output spikes per class over a frame, then scans the counters for the arg-max
// and presents the winner on a valid/ready port.
module snn_spike_classifier
   import snn_spike_classifier_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             w_en,
   input  logic [IDX_W-1:0] s_index_i,
   output logic             full,
   output logic             almost_full,
   input  logic             frame_end,
   output logic             result_valid,
   input  logic             result_ready,
   output logic [CLS_W-1:0] result_class,
   output logic [CNT_W-1:0] result_count,
   output logic [2:0]       err_flags
);
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

   state_t           r_state;
   logic             r_pending;
   logic [CLS_W-1:0] r_scan_i;
   logic [CNT_W-1:0] r_cnt [NUM_CLASS];
   logic             r_vld_p1;
   logic [ENT_W-1:0] r_ent_p1;

   logic [ENT_W-1:0] w_ent_p0;
   logic [ENT_W-1:0] w_fifo_dout;
   logic             w_empty;
   logic             w_pop_p0;
   logic             w_go_scan;
   logic             w_last;
   logic             w_accept;
   logic             w_take;
   logic [CNT_W-1:0] w_scan_cnt;

   assign w_ent_p0 = {(s_index_i >= IDX_W'(NUM_CLASS)), s_index_i[CLS_W-1:0]};

   spike_in_fifo #(
      .DW(ENT_W), .DEPTH(FIFO_DEPTH), .AW(FIFO_AW), .AF_MARGIN(AF_MARGIN)
   ) u_fifo (
      .clk(clk), .rst(rst),
      .i_push(w_en), .i_din(w_ent_p0),
      .i_pop(w_pop_p0), .o_dout(w_fifo_dout),
      .o_empty(w_empty), .o_full(full), .o_almost_full(almost_full)
   );

   assign w_pop_p0  = (r_state == ST_ACCUM) && !w_empty;
   assign w_go_scan = (r_state == ST_ACCUM) && r_pending && w_empty && !r_vld_p1;
   assign w_last    = (r_state == ST_SCAN) && (r_scan_i == CLS_W'(NUM_CLASS - 1));
   assign w_accept  = result_valid && result_ready;
   assign w_take    = w_scan_cnt > result_count;

   always_comb begin
      w_scan_cnt = '0;
      for (int c = 0; c < NUM_CLASS; c++)
         if (r_scan_i == CLS_W'(c)) w_scan_cnt = r_cnt[c];
   end

   // ---- p0 -> p1: popped entry registered ----
   always_ff @(posedge clk) begin
      if (w_pop_p0) r_ent_p1 <= w_fifo_dout;
   end

   // ---- p1: counter update; cleared in one cycle on result handshake ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < NUM_CLASS; c++) r_cnt[c] <= '0;
      end else if (w_accept) begin
         for (int c = 0; c < NUM_CLASS; c++) r_cnt[c] <= '0;
      end else if (r_vld_p1 && !r_ent_p1[CLS_W]) begin
         for (int c = 0; c < NUM_CLASS; c++)
            if (r_ent_p1[CLS_W-1:0] == CLS_W'(c)) r_cnt[c] <= sat_inc(r_cnt[c]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_ACCUM;
         r_pending    <= 1'b0;
         r_scan_i     <= '0;
         r_vld_p1     <= 1'b0;
         result_valid <= 1'b0;
         result_class <= '0;
         result_count <= '0;
         err_flags    <= '0;
      end else begin
         r_vld_p1 <= w_pop_p0;
         if (w_en && full)                     err_flags[ERR_WR_FULL] <= 1'b1;
         if (r_vld_p1 && r_ent_p1[CLS_W])      err_flags[ERR_BAD_IDX] <= 1'b1;
         if (frame_end && r_pending)           err_flags[ERR_FE_PEND] <= 1'b1;
         // A frame_end that collides with a still-pending frame is dropped.
         if (w_go_scan)      r_pending <= 1'b0;
         else if (frame_end) r_pending <= 1'b1;
         case (r_state)
            ST_ACCUM: if (w_go_scan) begin
               r_state      <= ST_SCAN;
               r_scan_i     <= '0;
               result_class <= '0;
               result_count <= '0;
            end
            ST_SCAN: begin
               if (w_take) begin
                  result_class <= r_scan_i;
                  result_count <= w_scan_cnt;
               end
               r_scan_i <= r_scan_i + CLS_W'(1);
               if (w_last) begin
                  r_state      <= ST_DONE;
                  result_valid <= 1'b1;
               end
            end
            ST_DONE: if (result_ready) begin
               result_valid <= 1'b0;
               r_state      <= ST_ACCUM;
            end
            default: r_state <= ST_ACCUM;
         endcase
      end
   end
endmodule

// File: tb/tb_snn_spike_classifier.sv
// Randomized and directed bench for snn_spike_classifier against a per-frame histogram model.
module tb_snn_spike_classifier;
   import snn_spike_classifier_pkg::*;

   logic             clk = 1'b0;
   logic             rst;
   logic             w_en;
   logic [IDX_W-1:0] s_index_i;
   logic             full;
   logic             almost_full;
   logic             frame_end;
   logic             result_valid;
   logic             result_ready;
   logic [CLS_W-1:0] result_class;
   logic [CNT_W-1:0] result_count;
   logic [2:0]       err_flags;

   int         n_chk  = 0;
   int         n_pass = 0;
   int         exp_cnt [NUM_CLASS];
   logic [2:0] exp_err;

   snn_spike_classifier dut (
      .clk(clk), .rst(rst), .w_en(w_en), .s_index_i(s_index_i),
      .full(full), .almost_full(almost_full), .frame_end(frame_end),
      .result_valid(result_valid), .result_ready(result_ready),
      .result_class(result_class), .result_count(result_count),
      .err_flags(err_flags)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      for (int c = 0; c < NUM_CLASS; c++) exp_cnt[c] = 0;
   endtask

   task automatic model_add(input int idx);
      if (idx >= NUM_CLASS) exp_err[ERR_BAD_IDX] = 1'b1;
      else if (exp_cnt[idx] < (1 << CNT_W) - 1) exp_cnt[idx]++;
   endtask

   task automatic spike(input int idx);
      w_en      = 1'b1;
      s_index_i = IDX_W'(idx);
      tick();
      w_en      = 1'b0;
   endtask

   task automatic spike_m(input int idx);
      spike(idx);
      model_add(idx);
   endtask

   task automatic end_frame(input string tag, input bit dbl, input int exp_lat);
      int k;
      int best_c;
      int best_n;
      frame_end = 1'b1;
      tick();
      k = 1;
      if (dbl) begin
         tick();
         k++;
      end
      frame_end = 1'b0;
      while (!result_valid && k < 400) begin
         tick();
         k++;
      end
      chk({tag, "_valid"}, result_valid, 1);
      if (exp_lat > 0) chk({tag, "_latency"}, k, exp_lat);
      best_c = 0;
      best_n = 0;
      for (int c = 0; c < NUM_CLASS; c++)
         if (exp_cnt[c] > best_n) begin
            best_c = c;
            best_n = exp_cnt[c];
         end
      chk({tag, "_class"}, result_class, best_c);
      chk({tag, "_count"}, result_count, best_n);
      chk({tag, "_err"}, err_flags, exp_err);
   endtask

   task automatic accept(input string tag);
      result_ready = 1'b1;
      tick();
      result_ready = 1'b0;
      chk({tag, "_drop"}, result_valid, 0);
      model_clear();
   endtask

   initial begin
      logic [CLS_W-1:0] hold_c;
      logic [CNT_W-1:0] hold_n;
      rst = 1'b1; w_en = 1'b0; s_index_i = '0; frame_end = 1'b0; result_ready = 1'b0;
      exp_err = '0;
      model_clear();
      repeat (3) tick();
      chk("rst_valid", result_valid, 0);
      chk("rst_full", full, 0);
      chk("rst_af", almost_full, 0);
      chk("rst_err", err_flags, 0);
      chk("rst_class", result_class, 0);
      chk("rst_count", result_count, 0);
      rst = 1'b0;
      tick();

      // T1 / T2
      spike_m(3); spike_m(3); spike_m(7); spike_m(3);
      end_frame("t1", 1'b0, 0);
      accept("t1");
      spike_m(5); spike_m(5); spike_m(2); spike_m(2);
      end_frame("t2_tie", 1'b0, 0);
      accept("t2_tie");
      end_frame("t2_empty", 1'b0, 12);
      accept("t2_empty");

      // Randomized frames with idle gaps and random consumer delay
      for (int f = 0; f < 10; f++) begin
         int n;
         n = $urandom_range(0, 40);
         for (int s = 0; s < n; s++) begin
            spike_m($urandom_range(0, NUM_CLASS - 1));
            if ($urandom_range(0, 3) == 0) tick();
         end
         end_frame($sformatf("rnd%0d", f), 1'b0, 0);
         hold_c = result_class;
         hold_n = result_count;
         for (int d = $urandom_range(0, 4); d > 0; d--) begin
            tick();
            chk("rnd_hold", {result_valid, result_class, result_count}, {1'b1, hold_c, hold_n});
         end
         accept($sformatf("rnd%0d", f));
      end

      // T3: saturation
      for (int s = 0; s < 300; s++) spike_m(1);
      end_frame("t3_sat", 1'b0, 0);
      accept("t3_sat");

      // T4: backpressure while result is held
      spike_m(0); spike_m(0);
      end_frame("t4_pre", 1'b0, 0);
      for (int s = 1; s <= 20; s++) begin
         spike(4);
         if (s == 13) chk("t4_af13", almost_full, 0);
         if (s == 14) chk("t4_af14", almost_full, 1);
         if (s == 15) chk("t4_full15", full, 0);
         if (s == 16) chk("t4_full16", full, 1);
      end
      exp_err[ERR_WR_FULL] = 1'b1;
      chk("t4_full", full, 1);
      chk("t4_err", err_flags, exp_err);
      chk("t4_hold", {result_valid, result_class, result_count}, {1'b1, CLS_W'(0), CNT_W'(2)});
      accept("t4_pre");
      for (int s = 0; s < 16; s++) model_add(4);
      end_frame("t4_next", 1'b0, 0);
      chk("t4_full_after", full, 0);
      accept("t4_next");

      // T5: out-of-range index and double frame_end
      spike_m(6); spike_m(12); spike_m(6);
      exp_err[ERR_FE_PEND] = 1'b1;
      end_frame("t5", 1'b1, 0);
      accept("t5");
      repeat (30) tick();
      chk("t5_no_second", result_valid, 0);

      // T6: reset during SCAN
      spike(8); spike(8);
      frame_end = 1'b1;
      tick();
      frame_end = 1'b0;
      repeat (5) tick();
      #2 rst = 1'b1;
      #1;
      chk("t6_valid", result_valid, 0);
      chk("t6_full", full, 0);
      chk("t6_err", err_flags, 0);
      #2 rst = 1'b0;
      exp_err = '0;
      model_clear();
      tick();
      spike_m(8); spike_m(9); spike_m(9);
      end_frame("t6_fresh", 1'b0, 0);
      accept("t6_fresh");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
